// File: rtl/haar_coef_serializer.sv
// ---------------------------------------------------------------------------
// haar_coef_serializer
//
// Buffers the strobed coefficient words of the Haar analysis filter bank and
// emits them as one serial (word index, signed value) stream over a
// valid/ready handshake. Words are granted round-robin; a new strobe for a
// word whose previous value was never granted overwrites it (newest wins)
// and raises that word's sticky overflow flag.
//
// Parameters:
//   STAGES     number of filter stages (2..8); STAGES+1 coefficient words
//   OUT_WIDTH  width of each signed coefficient word (>= 2)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   inStrobes  per-word "new value" pulse, bit i for word i
//   dataIn     packed words, word i at [OUT_WIDTH*i +: OUT_WIDTH]
//   clrOvf     synchronous clear of the overflow flags (a same-edge set wins)
//   outReady   downstream accepts the current output word
//   outValid   outData/outIndex hold a word
//   outData    signed coefficient value, passed through unmodified
//   outIndex   source word index 0..STAGES
//   overflow   sticky per-word overrun flags
//   thresh     (HAAR_SER_THRESHOLD_EN only) unsigned magnitude threshold;
//              strobes on words 1..STAGES with |word| < thresh are ignored
//
// Optional feature macro: HAAR_SER_THRESHOLD_EN
// ---------------------------------------------------------------------------
module haar_coef_serializer #(
    parameter int STAGES    = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [STAGES:0]                  inStrobes,
    input  logic [OUT_WIDTH*(STAGES+1)-1:0]  dataIn,
    input  logic                             clrOvf,
    input  logic                             outReady,
`ifdef HAAR_SER_THRESHOLD_EN
    input  logic [OUT_WIDTH-1:0]             thresh,
`endif
    output logic                             outValid,
    output logic [OUT_WIDTH-1:0]             outData,
    output logic [3:0]                       outIndex,
    output logic [STAGES:0]                  overflow
);

    localparam int unsigned NW = STAGES + 1;

    if (STAGES < 2 || STAGES > 8 || OUT_WIDTH < 2) begin : g_bad_param
        $fatal(1, "haar_coef_serializer: STAGES must be 2..8 and OUT_WIDTH >= 2");
    end

    logic [OUT_WIDTH-1:0] hold [NW];
    logic [NW-1:0]        pend;
    logic [NW-1:0]        accept;
    logic [NW-1:0]        ovf_set;
    logic [3:0]           ptr;
    logic [3:0]           gnt_idx;
    logic [OUT_WIDTH-1:0] gnt_data;
    logic                 gnt_found;
    logic                 load;

    // Strobe qualification
    for (genvar gi = 0; gi < STAGES + 1; gi++) begin : g_acc
`ifdef HAAR_SER_THRESHOLD_EN
        if (gi == 0) begin : g_lowpass
            assign accept[gi] = inStrobes[gi];
        end else begin : g_highpass
            // One extra bit so the most negative word has a representable magnitude.
            logic [OUT_WIDTH:0] ext;
            logic [OUT_WIDTH:0] mag;
            assign ext = {dataIn[OUT_WIDTH*gi + OUT_WIDTH - 1], dataIn[OUT_WIDTH*gi +: OUT_WIDTH]};
            assign mag = ext[OUT_WIDTH] ? (~ext + (OUT_WIDTH+1)'(1)) : ext;
            assign accept[gi] = inStrobes[gi] && (mag >= {1'b0, thresh});
        end
`else
        assign accept[gi] = inStrobes[gi];
`endif
    end

    // Round-robin search: first pass covers ptr..STAGES, second wraps to 0..ptr-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_data  = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (!gnt_found && pend[i] && 4'(i) >= ptr) begin
                gnt_found = 1'b1;
                gnt_idx   = 4'(i);
                gnt_data  = hold[i];
            end
        end
        for (int unsigned i = 0; i < NW; i++) begin
            if (!gnt_found && pend[i] && 4'(i) < ptr) begin
                gnt_found = 1'b1;
                gnt_idx   = 4'(i);
                gnt_data  = hold[i];
            end
        end
    end

    assign load = (!outValid || outReady) && gnt_found;

    // A strobe on the edge its word is granted is a hand-over, not an overrun.
    always_comb begin
        ovf_set = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            ovf_set[i] = accept[i] && pend[i] && !(load && gnt_idx == 4'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            ptr      <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outIndex <= '0;
            overflow <= '0;
            for (int unsigned i = 0; i < NW; i++) begin
                hold[i] <= '0;
            end
        end else begin
            overflow <= (clrOvf ? '0 : overflow) | ovf_set;

            if (load) begin
                outValid <= 1'b1;
                outData  <= gnt_data;
                outIndex <= gnt_idx;
                ptr      <= (gnt_idx == 4'(STAGES)) ? '0 : gnt_idx + 4'd1;
            end else if (outReady) begin
                outValid <= 1'b0;
            end

            // Capture takes precedence over the grant's pend clear, so a
            // same-edge strobe leaves the new value pending.
            for (int unsigned i = 0; i < NW; i++) begin
                if (accept[i]) begin
                    hold[i] <= dataIn[OUT_WIDTH*i +: OUT_WIDTH];
                    pend[i] <= 1'b1;
                end else if (load && gnt_idx == 4'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_haar_coef_serializer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for haar_coef_serializer: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_haar_coef_serializer;

    localparam int STAGES = 4;
    localparam int W      = 16;
    localparam int N      = STAGES + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     inStrobes;
    logic [W*N-1:0]   dataIn;
    logic             clrOvf;
    logic             outReady;
    logic             outValid;
    logic [W-1:0]     outData;
    logic [3:0]       outIndex;
    logic [N-1:0]     overflow;
`ifdef HAAR_SER_THRESHOLD_EN
    logic [W-1:0]     thresh;
`endif

    haar_coef_serializer #(.STAGES(STAGES), .OUT_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .inStrobes (inStrobes),
        .dataIn    (dataIn),
        .clrOvf    (clrOvf),
        .outReady  (outReady),
`ifdef HAAR_SER_THRESHOLD_EN
        .thresh    (thresh),
`endif
        .outValid  (outValid),
        .outData   (outData),
        .outIndex  (outIndex),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0] m_val [N];
    bit   [N-1:0] m_pend;
    int           m_ptr;
    bit           m_v;
    logic [W-1:0] m_d;
    int           m_i;
    bit   [N-1:0] m_ovf;
    int           m_thr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_val[i] = '0;
        m_pend = '0;
        m_ptr  = 0;
        m_v    = 0;
        m_d    = '0;
        m_i    = 0;
        m_ovf  = '0;
    endtask

    function automatic bit accepted(int i);
        int v;
        v = int'($signed(dataIn[W*i +: W]));
        if (i == 0 || m_thr == 0) return 1'b1;
        if (v < 0) v = -v;
        return v >= m_thr;
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        int           g;
        bit           ld;
        bit [N-1:0]   pre;
        bit [N-1:0]   setv;
        pre = m_pend;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && m_pend[c]) g = c;
        end
        ld = (!m_v || outReady) && (g >= 0);
        if (ld) begin
            m_v       = 1;
            m_d       = m_val[g];
            m_i       = g;
            m_pend[g] = 0;
            m_ptr     = (g + 1) % N;
        end else if (outReady) begin
            m_v = 0;
        end
        setv = '0;
        for (int i = 0; i < N; i++) begin
            if (inStrobes[i] && accepted(i)) begin
                if (pre[i] && !(ld && g == i)) setv[i] = 1;
                m_val[i]  = dataIn[W*i +: W];
                m_pend[i] = 1;
            end
        end
        m_ovf = (clrOvf ? '0 : m_ovf) | setv;
    endtask

    task automatic check_all();
        chk("outValid", 32'(outValid), 32'(m_v));
        chk("outData",  32'(outData),  32'(m_d));
        chk("outIndex", 32'(outIndex), 32'(m_i));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        inStrobes = '0;
        clrOvf    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #2;
        check_all();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic strobe(input int i, input logic [W-1:0] v);
        inStrobes[i]      = 1'b1;
        dataIn[W*i +: W]  = v;
    endtask

    logic [W-1:0] exp2 [N];

    initial begin
        rst = 1'b1; inStrobes = '0; dataIn = '0; clrOvf = 1'b0; outReady = 1'b0;
        m_thr = 0;
`ifdef HAAR_SER_THRESHOLD_EN
        thresh = '0;
`endif
        // Single strobe
        do_reset();
        outReady = 1'b1;
        strobe(0, 16'h1234);
        cycle();
        chk("t1_idle", 32'(outValid), 32'd0);
        cycle();
        chk("t1_valid", 32'(outValid), 32'd1);
        chk("t1_data",  32'(outData),  32'h1234);
        chk("t1_index", 32'(outIndex), 32'd0);
        cycle();
        chk("t1_drop", 32'(outValid), 32'd0);

        // Simultaneous strobes, pointer at 0
        do_reset();
        outReady = 1'b1;
        exp2 = '{16'hFFFF, 16'd2, 16'hFFFD, 16'd4, 16'd5};
        for (int i = 0; i < N; i++) strobe(i, exp2[i]);
        cycle();
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("t2_valid", 32'(outValid), 32'd1);
            chk("t2_index", 32'(outIndex), 32'(k));
            chk("t2_data",  32'(outData),  32'(exp2[k]));
        end
        chk("t2_ovf", 32'(overflow), 32'd0);

        // Backpressure and overrun
        do_reset();
        outReady = 1'b0;
        strobe(0, 16'd7);
        cycle();
        cycle();
        strobe(4, 16'd100);
        cycle();
        strobe(4, 16'd200);
        cycle();
        chk("t3_ovf4", 32'(overflow[4]), 32'd1);
        cycle();
        chk("t3_hold", 32'(outData), 32'd7);
        outReady = 1'b1;
        cycle();
        chk("t3_new_data",  32'(outData),  32'd200);
        chk("t3_new_index", 32'(outIndex), 32'd4);
        clrOvf = 1'b1;
        cycle();
        chk("t3_clr", 32'(overflow), 32'd0);

        // Strobe during grant
        do_reset();
        outReady = 1'b1;
        strobe(2, 16'h0AAA);
        cycle();
        strobe(2, 16'h0BBB);
        cycle();
        chk("t4_old", 32'(outData), 32'h0AAA);
        cycle();
        chk("t4_new", 32'(outData), 32'h0BBB);
        chk("t4_ovf2", 32'(overflow[2]), 32'd0);

        // Async reset mid-stream
        do_reset();
        outReady = 1'b0;
        for (int i = 0; i < N; i++) strobe(i, W'($urandom));
        cycle();
        cycle();
        strobe(1, 16'h5555);
        cycle();
        chk("t5_pre_ovf", 32'(overflow[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(outValid), 32'd0);
        chk("t5_rst_ovf",   32'(overflow), 32'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        outReady = 1'b1;
        repeat (6) begin
            cycle();
            chk("t5_no_stale", 32'(outValid), 32'd0);
        end

`ifdef HAAR_SER_THRESHOLD_EN
        // Threshold filtering
        do_reset();
        outReady = 1'b1;
        thresh = 16'd10; m_thr = 10;
        strobe(3, -16'sd9);
        cycle(); cycle();
        chk("th_drop", 32'(outValid), 32'd0);
        strobe(3, -16'sd10);
        cycle(); cycle();
        chk("th_keep", 32'(outData), 32'(16'hFFF6));
        strobe(0, 16'd0);
        cycle(); cycle();
        chk("th_w0", 32'(outValid), 32'd1);
        strobe(1, 16'h8000);
        cycle(); cycle();
        chk("th_min", 32'(outData), 32'h8000);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                inStrobes[i]     = ($urandom_range(3) == 0);
                dataIn[W*i +: W] = W'($urandom);
            end
            outReady = ($urandom_range(3) != 0);
            clrOvf   = ($urandom_range(15) == 0);
`ifdef HAAR_SER_THRESHOLD_EN
            if ($urandom_range(63) == 0) begin
                thresh = W'($urandom_range(40000));
                m_thr  = int'(thresh);
            end
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
